// File: rtl/mod15_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mod15_seq_ctrl
// Description : Two-requester command sequencer for an external up/down
//               counter. It arbitrates LOAD/UP/DOWN/CLEAR commands, drives
//               the counter control inputs, and reports completion together
//               with the counter value seen in the completion cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mod15_seq_ctrl #(
  parameter int ARB_RR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [1:0] req0_op,
  input  logic [3:0] req0_arg,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_op,
  input  logic [3:0] req1_arg,
  output logic       req1_ready,
  output logic       cnt_load,
  output logic       cnt_mode,
  output logic [3:0] cnt_data,
  input  logic [3:0] cnt_value,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [3:0] done_value
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC_LD = 2'd1,
    COUNT   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] arg_q, arg_d;
  logic       id_q, id_d;
  logic [3:0] step_q, step_d;
  logic       last_q, last_d;

  logic       gnt_valid;
  logic       gnt_id;
  logic [1:0] gnt_op;
  logic [3:0] gnt_arg;

  // State register; reset leaves the pointer at 1 so req0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      arg_q   <= 4'd0;
      id_q    <= 1'b0;
      step_q  <= 4'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      id_q    <= id_d;
      step_q  <= step_d;
      last_q  <= last_d;
    end
  end

  // Arbiter: on a tie, round-robin picks the requester not granted last,
  // fixed priority always picks req0; a lone requester always wins.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id = (ARB_RR != 0) ? ~last_q : 1'b0;
    end else begin
      gnt_id = ~req0_valid;
    end
    gnt_op  = gnt_id ? req1_op  : req0_op;
    gnt_arg = gnt_id ? req1_arg : req0_arg;
  end

  // Next-state and output decode; outputs are forced quiet while in reset.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    arg_d      = arg_q;
    id_d       = id_q;
    step_d     = step_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    cnt_load   = 1'b0;
    cnt_mode   = 1'b0;
    cnt_data   = 4'd0;
    busy       = 1'b0;
    done       = 1'b0;
    done_id    = 1'b0;
    done_value = 4'd0;

    case (state_q)
      IDLE: begin
        // Hold the counter by reloading its own value.
        cnt_load = 1'b1;
        cnt_data = cnt_value;
        if (gnt_valid) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          op_d       = gnt_op;
          arg_d      = gnt_arg;
          id_d       = gnt_id;
          last_d     = gnt_id;
          if (gnt_op == OP_LOAD || gnt_op == OP_CLEAR) begin
            state_d = EXEC_LD;
          end else if (gnt_arg == 4'd0) begin
            state_d = DONE;
          end else begin
            state_d = COUNT;
            step_d  = gnt_arg;
          end
        end
      end
      EXEC_LD: begin
        busy     = 1'b1;
        cnt_load = 1'b1;
        cnt_data = (op_q == OP_LOAD) ? arg_q : 4'd0;
        state_d  = DONE;
      end
      COUNT: begin
        // One counter step per cycle; leave once the last step is issued.
        busy     = 1'b1;
        cnt_mode = (op_q == OP_UP);
        step_d   = step_q - 4'd1;
        if (step_q <= 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        cnt_load   = 1'b1;
        cnt_data   = cnt_value;
        done       = 1'b1;
        done_id    = id_q;
        done_value = cnt_value;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      cnt_load   = 1'b0;
      cnt_mode   = 1'b0;
      cnt_data   = 4'd0;
      busy       = 1'b0;
      done       = 1'b0;
      done_id    = 1'b0;
      done_value = 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod15_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod15_seq_ctrl
// Description : Bench for mod15_seq_ctrl. Drives a round-robin and a fixed-
//               priority instance with identical requests, each attached to
//               its own behavioural counter, and checks both against a
//               latency-based transaction model, a vector table and a few
//               directed sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod15_seq_ctrl;

  localparam logic [1:0] LD = 2'd0;
  localparam logic [1:0] UP = 2'd1;
  localparam logic [1:0] DN = 2'd2;
  localparam logic [1:0] CL = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1;
  logic [1:0] op0, op1;
  logic [3:0] a0, a1;

  logic [1:0] rdy0_w, rdy1_w, ld_w, md_w, busy_w, done_w, did_w;
  logic [3:0] dat_w [2];
  logic [3:0] dv_w  [2];
  logic [3:0] cval  [2] = '{4'd0, 4'd0};

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mod15_seq_ctrl #(.ARB_RR(1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_op(op0), .req0_arg(a0), .req0_ready(rdy0_w[0]),
    .req1_valid(v1), .req1_op(op1), .req1_arg(a1), .req1_ready(rdy1_w[0]),
    .cnt_load(ld_w[0]), .cnt_mode(md_w[0]), .cnt_data(dat_w[0]),
    .cnt_value(cval[0]), .busy(busy_w[0]), .done(done_w[0]),
    .done_id(did_w[0]), .done_value(dv_w[0])
  );

  mod15_seq_ctrl #(.ARB_RR(0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_op(op0), .req0_arg(a0), .req0_ready(rdy0_w[1]),
    .req1_valid(v1), .req1_op(op1), .req1_arg(a1), .req1_ready(rdy1_w[1]),
    .cnt_load(ld_w[1]), .cnt_mode(md_w[1]), .cnt_data(dat_w[1]),
    .cnt_value(cval[1]), .busy(busy_w[1]), .done(done_w[1]),
    .done_id(did_w[1]), .done_value(dv_w[1])
  );

  // External counters: up wraps 14 -> 0, down is plain 4-bit (0 -> 15).
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ld_w[i])      cval[i] <= dat_w[i];
      else if (md_w[i]) cval[i] <= (cval[i] >= 4'd14) ? 4'd0 : cval[i] + 4'd1;
      else              cval[i] <= cval[i] - 4'd1;
    end
  end

  // Transaction model: one command in flight, completing lat cycles after grant.
  bit         m_busy [2];
  bit         m_id   [2];
  logic [1:0] m_op   [2];
  logic [3:0] m_arg  [2];
  int         m_age  [2];
  int         m_lat  [2];
  logic [3:0] m_res  [2];
  bit         m_last [2];

  // Samples of the last stepped cycle, for directed checks.
  logic [1:0] s_rdy  [2];
  logic       s_busy [2];
  logic       s_done [2];
  logic       s_id   [2];
  logic [3:0] s_dv   [2];
  logic       s_load [2];
  logic [3:0] s_data [2];
  logic [3:0] s_cv   [2];

  function automatic logic [3:0] apply_op(logic [1:0] op, logic [3:0] arg, logic [3:0] v);
    logic [3:0] r;
    r = v;
    case (op)
      LD: r = arg;
      CL: r = 4'd0;
      UP: for (int k = 0; k < int'(arg); k++) r = (r >= 4'd14) ? 4'd0 : r + 4'd1;
      default: for (int k = 0; k < int'(arg); k++) r = r - 4'd1;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
  endtask

  // One cycle: apply inputs, check both instances at the falling edge, advance model.
  task automatic step(input bit r, input bit x_v0, input logic [1:0] x_op0, input logic [3:0] x_a0,
                      input bit x_v1, input logic [1:0] x_op1, input logic [3:0] x_a1);
    bit         n_busy [2];
    bit         n_id   [2];
    logic [1:0] n_op   [2];
    logic [3:0] n_arg  [2];
    int         n_age  [2];
    int         n_lat  [2];
    logic [3:0] n_res  [2];
    bit         n_last [2];
    bit e_r0, e_r1, e_busy, e_done, e_id, e_load, e_mode, chk_data;
    logic [3:0] e_data, e_dv;
    int g;
    rst = r; v0 = x_v0; op0 = x_op0; a0 = x_a0; v1 = x_v1; op1 = x_op1; a1 = x_a1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_busy[i] = m_busy[i]; n_id[i] = m_id[i]; n_op[i] = m_op[i]; n_arg[i] = m_arg[i];
      n_age[i] = m_age[i]; n_lat[i] = m_lat[i]; n_res[i] = m_res[i]; n_last[i] = m_last[i];
      e_r0 = 0; e_r1 = 0; e_busy = 0; e_done = 0; e_id = 0; e_load = 0; e_mode = 0;
      e_data = 4'd0; e_dv = 4'd0; chk_data = 1;
      if (r) begin
        if (!m_busy[i]) begin
          e_load = 1; e_data = cval[i];
          g = -1;
          if (x_v0 && x_v1) g = (i == 0) ? (m_last[i] ? 0 : 1) : 0;
          else if (x_v0)    g = 0;
          else if (x_v1)    g = 1;
          if (g >= 0) begin
            e_r0 = (g == 0); e_r1 = (g == 1);
            n_busy[i] = 1; n_id[i] = (g == 1); n_last[i] = (g == 1); n_age[i] = 1;
            n_op[i]  = (g == 1) ? x_op1 : x_op0;
            n_arg[i] = (g == 1) ? x_a1  : x_a0;
            if (n_op[i] == LD || n_op[i] == CL) n_lat[i] = 2;
            else n_lat[i] = (n_arg[i] == 0) ? 1 : int'(n_arg[i]) + 1;
            n_res[i] = apply_op(n_op[i], n_arg[i], cval[i]);
          end
        end else begin
          e_busy = 1;
          n_age[i] = m_age[i] + 1;
          if (m_age[i] == m_lat[i]) begin
            e_done = 1; e_id = m_id[i]; e_dv = m_res[i]; e_load = 1; e_data = cval[i];
            n_busy[i] = 0;
          end else if (m_op[i] == LD || m_op[i] == CL) begin
            e_load = 1; e_data = (m_op[i] == LD) ? m_arg[i] : 4'd0;
          end else begin
            e_mode = (m_op[i] == UP); chk_data = 0;
          end
        end
      end else begin
        n_busy[i] = 0; n_last[i] = 1; n_age[i] = 0;
      end
      chk("req0_ready", i, int'(rdy0_w[i]), int'(e_r0));
      chk("req1_ready", i, int'(rdy1_w[i]), int'(e_r1));
      chk("busy",       i, int'(busy_w[i]), int'(e_busy));
      chk("done",       i, int'(done_w[i]), int'(e_done));
      chk("cnt_load",   i, int'(ld_w[i]),   int'(e_load));
      chk("cnt_mode",   i, int'(md_w[i]),   int'(e_mode));
      if (chk_data) chk("cnt_data", i, int'(dat_w[i]), int'(e_data));
      if (e_done) begin
        chk("done_id",    i, int'(did_w[i]), int'(e_id));
        chk("done_value", i, int'(dv_w[i]),  int'(e_dv));
      end
      s_rdy[i] = {rdy1_w[i], rdy0_w[i]}; s_busy[i] = busy_w[i]; s_done[i] = done_w[i];
      s_id[i] = did_w[i]; s_dv[i] = dv_w[i]; s_load[i] = ld_w[i]; s_data[i] = dat_w[i];
      s_cv[i] = cval[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = n_busy[i]; m_id[i] = n_id[i]; m_op[i] = n_op[i]; m_arg[i] = n_arg[i];
      m_age[i] = n_age[i]; m_lat[i] = n_lat[i]; m_res[i] = n_res[i]; m_last[i] = n_last[i];
    end
  endtask

  task automatic idle();
    step(1, 0, LD, 4'd0, 0, LD, 4'd0);
  endtask

  typedef struct {
    bit         r;
    bit         v0;
    logic [1:0] o0;
    logic [3:0] x0;
    bit         v1;
    logic [1:0] o1;
    logic [3:0] x1;
    logic [1:0] rdy_rr;
    bit         dn_rr;
    bit         id_rr;
    logic [1:0] rdy_fp;
    bit         dn_fp;
    bit         id_fp;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Both requesters issue LOADs back to back: the tie pattern shows arbitration.
    tbl[0]  = '{1'b0, 1'b1, LD, 4'd5, 1'b1, LD, 4'd6, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, LD, 4'd5, 1'b1, LD, 4'd6, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, LD, 4'd5, 1'b1, LD, 4'd6, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, LD, 4'd5, 1'b1, LD, 4'd6, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, LD, 4'd5, 1'b1, LD, 4'd6, 2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, LD, 4'd5, 1'b1, LD, 4'd6, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, LD, 4'd5, 1'b1, LD, 4'd6, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, LD, 4'd5, 1'b1, LD, 4'd6, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, LD, 4'd5, 1'b1, LD, 4'd6, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, LD, 4'd5, 1'b1, LD, 4'd6, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, LD, 4'd5, 1'b1, LD, 4'd6, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, LD, 4'd5, 1'b1, LD, 4'd6, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, LD, 4'd5, 1'b1, LD, 4'd6, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1};

    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_last[i] = 1; m_age[i] = 0; m_lat[i] = 0; m_id[i] = 0;
      m_op[i] = LD; m_arg[i] = 4'd0; m_res[i] = 4'd0;
    end
    rst = 0; v0 = 0; v1 = 0; op0 = LD; op1 = LD; a0 = 4'd0; a1 = 4'd0;

    step(0, 0, LD, 4'd0, 0, LD, 4'd0);
    step(0, 0, LD, 4'd0, 0, LD, 4'd0);

    for (int k = 0; k < 13; k++) begin
      step(tbl[k].r, tbl[k].v0, tbl[k].o0, tbl[k].x0, tbl[k].v1, tbl[k].o1, tbl[k].x1);
      chk("tbl_rdy_rr", 0, int'(s_rdy[0]),  int'(tbl[k].rdy_rr));
      chk("tbl_done_rr", 0, int'(s_done[0]), int'(tbl[k].dn_rr));
      if (tbl[k].dn_rr) chk("tbl_id_rr", 0, int'(s_id[0]), int'(tbl[k].id_rr));
      chk("tbl_rdy_fp", 1, int'(s_rdy[1]),  int'(tbl[k].rdy_fp));
      chk("tbl_done_fp", 1, int'(s_done[1]), int'(tbl[k].dn_fp));
      if (tbl[k].dn_fp) chk("tbl_id_fp", 1, int'(s_id[1]), int'(tbl[k].id_fp));
    end

    // LOAD 9 then UP 0: value reaches the counter at T+1, reported at T+2.
    step(1, 1, LD, 4'd9, 0, LD, 4'd0);
    idle();
    chk("ld9_load", 0, int'(s_load[0]), 1);
    chk("ld9_data", 0, int'(s_data[0]), 9);
    idle();
    chk("ld9_done", 0, int'(s_done[0]), 1);
    chk("ld9_val",  0, int'(s_dv[0]),   9);
    step(1, 1, UP, 4'd0, 0, LD, 4'd0);
    idle();
    chk("up0_done", 0, int'(s_done[0]), 1);
    chk("up0_val",  0, int'(s_dv[0]),   9);

    // UP 3 from 13 crosses the 14 -> 0 wrap.
    step(1, 1, LD, 4'd13, 0, LD, 4'd0);
    idle(); idle();
    step(1, 1, UP, 4'd3, 0, LD, 4'd0);
    idle();
    chk("up3_busy1", 0, int'(s_done[0]), 0);
    idle();
    chk("up3_cv14", 0, int'(s_cv[0]), 14);
    idle();
    chk("up3_cv0",  0, int'(s_cv[0]), 0);
    idle();
    chk("up3_done", 0, int'(s_done[0]), 1);
    chk("up3_id",   0, int'(s_id[0]),   0);
    chk("up3_val",  0, int'(s_dv[0]),   1);

    // DOWN 2 from 0 via req1 underflows to 15 then 14.
    step(1, 0, LD, 4'd0, 1, CL, 4'd7);
    idle(); idle();
    step(1, 0, LD, 4'd0, 1, DN, 4'd2);
    idle(); idle();
    chk("dn2_cv15", 0, int'(s_cv[0]), 15);
    idle();
    chk("dn2_done", 0, int'(s_done[0]), 1);
    chk("dn2_id",   0, int'(s_id[0]),   1);
    chk("dn2_val",  0, int'(s_dv[0]),   14);

    // Reset in the middle of UP 10 aborts it silently.
    step(1, 1, UP, 4'd10, 0, LD, 4'd0);
    idle(); idle(); idle();
    chk("abort_busy_pre", 0, int'(s_busy[0]), 1);
    step(0, 0, LD, 4'd0, 0, LD, 4'd0);
    chk("abort_rst_busy", 0, int'(s_busy[0]), 0);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("abort_busy", 0, int'(s_busy[0]), 0);
      chk("abort_done", 0, int'(s_done[0]), 0);
    end
    step(1, 1, LD, 4'd3, 1, LD, 4'd4);
    chk("abort_regrant", 0, int'(s_rdy[0]), 1);
    idle(); idle(); idle();

    // Random traffic against the model, with occasional resets.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 59) != 0,
           $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod15_seq_ctrl.md
MOD15_SEQ_CTRL -- requirements
Module: mod15_seq_ctrl

Interface
REQ-001 SHALL have parameter ARB_RR, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with req0 highest.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1, command pending from requester 0 / 1.
REQ-005 SHALL have ports req0_op / req1_op, input, 2, opcode: 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
REQ-006 SHALL have ports req0_arg / req1_arg, input, 4, LOAD value or UP/DOWN step count.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1, command accepted this cycle.
REQ-008 SHALL have port cnt_load, output, 1, drives the counter load input.
REQ-009 SHALL have port cnt_mode, output, 1, drives the counter mode input: 1 up, 0 down.
REQ-010 SHALL have port cnt_data, output, 4, drives the counter data input.
REQ-011 SHALL have port cnt_value, input, 4, the counter's registered output.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port done_id, output, 1, index of the requester whose command completed.
REQ-015 SHALL have port done_value, output, 4, cnt_value sampled in the done cycle.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC_LD, COUNT, DONE.
REQ-017 IDLE and DONE SHALL hold the counter: cnt_load=1, cnt_data=cnt_value, cnt_mode=0.
REQ-018 IDLE with any valid request SHALL grant exactly one requester: ready high combinationally that cycle, op/arg/id captured.
REQ-019 Arbitration when both requests are valid, ARB_RR=1: grant the requester not granted last; last-grant pointer resets to 1, so req0 wins first.
REQ-020 Arbitration when both requests are valid, ARB_RR=0: req0 always wins.
REQ-021 A lone valid requester SHALL be granted regardless of the pointer.
REQ-022 readys SHALL be 0 outside IDLE, and both readys SHALL never be high together.
REQ-023 Grant of LOAD/CLEAR (cycle T) SHALL lead to EXEC_LD at T+1, driving cnt_load=1 and cnt_data=arg (LOAD) or 0 (CLEAR); DONE follows at T+2.
REQ-024 Grant of UP/DOWN with arg=N>0 at T SHALL spend N cycles in COUNT: cnt_load=0, cnt_mode=1 (UP) or 0 (DOWN), 4-bit step counter loaded with N and decremented each cycle. Exit to DONE when it reaches 1, so DONE is at T+N+1.
REQ-025 UP/DOWN with arg=0 SHALL go directly to DONE at T+1 with no counting.
REQ-026 DONE SHALL last one cycle with done=1, done_id=captured id, done_value=cnt_value; return to IDLE at the next cycle.
REQ-027 The controller SHALL NOT model counter wrap behaviour: done_value reports whatever cnt_value shows, including the 14->0 wrap and 0->15 underflow.
REQ-028 A new grant SHALL be possible at the earliest in the IDLE cycle following DONE, i.e. there is no back-to-back grant from DONE.
REQ-029 The last-grant pointer SHALL update only on a grant.
REQ-030 Request inputs SHALL be ignored while busy=1.

Reset
REQ-031 While rst=0 at a clock edge, the next state SHALL be IDLE, the step counter 0, and the pointer 1.
REQ-032 Outputs while rst=0 SHALL be: cnt_load=0, cnt_mode=0, cnt_data=0, readys=0, busy=0, done=0, done_id=0, done_value=0.
REQ-033 Reset mid-operation SHALL abort the command with no done pulse; the aborted command is not retried.

Verification
REQ-034 Scenario: cnt_value=13, req0 UP arg=3 granted at T -> COUNT T+1..T+3, cnt_value 14,0,1; done at T+4, done_id=0, done_value=1.
REQ-035 Scenario: cnt_value=0, req1 DOWN arg=2 -> cnt_value 15 then 14; done 3 cycles after grant with done_value=14.
REQ-036 Scenario: both valid continuously, ARB_RR=1, all ops LOAD -> grants alternate req0, req1, req0, and each done follows its grant by 2 cycles.
REQ-037 Scenario: both valid, ARB_RR=0 -> req0 granted every time; req1 granted only once req0_valid drops.
REQ-038 Scenario: req0 LOAD arg=9 -> cnt_load=1 and cnt_data=9 at T+1; done_value=9 at T+2. Then UP arg=0 -> done the next cycle with done_value=9.
REQ-039 Scenario: rst=0 asserted during COUNT of UP arg=10 -> IDLE at the next cycle, busy=0, no done pulse, next simultaneous request grants req0.
